// File: rtl/issue_queue.sv
// Age-ordered issue queue: buffers renamed ops, tracks physical-register readiness
// from writeback buses and presents the oldest op whose sources are all ready.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 38
`endif
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OP_W      = `RENAMED_OP_SZ,
  parameter int unsigned PR_ADDR_W = `PR_ADDR_W,
  parameter int unsigned NUM_WB    = 5,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [OP_W-1:0]             in_op,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OP_W-1:0]             out_op,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic [PR_ADDR_W*NUM_WB-1:0] wb_tags,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic                        flush,
  output logic [CNT_W-1:0]            count
);
  localparam int unsigned NUM_PR = 1 << PR_ADDR_W;

  typedef logic [PR_ADDR_W-1:0] tag_t;

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [3:0]        rdy_q  [DEPTH];
  logic [3:0]        rdy_d  [DEPTH];
  logic [3:0]        rdy_woke [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NUM_PR-1:0] sb_q, sb_d, wb_set;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              accept, issue;
  logic [CNT_W-1:0]  tail;
  logic [3:0]        in_rdy;
  tag_t              dest_val, dest_flag;

  function automatic tag_t src_tag(input logic [OP_W-1:0] op, input int k);
    return op[8 + 5*k +: PR_ADDR_W];
  endfunction

  // One-hot set of tags being written back this cycle.
  always_comb begin
    wb_set = '0;
    for (int w = 0; w < int'(NUM_WB); w++) begin
      if (wb_valid[w]) wb_set[wb_tags[w*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
    end
  end

  // Oldest-first select over registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (&rdy_q[i])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign out_valid = sel_found;
  assign out_op    = sel_found ? op_q[sel_idx] : op_q[0];
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign count     = count_q;
  assign accept    = in_valid & in_ready;
  assign issue     = sel_found & out_ready;
  assign tail      = count_q - CNT_W'(issue);
  assign dest_val  = in_op[28 +: PR_ADDR_W];
  assign dest_flag = in_op[33 +: PR_ADDR_W];

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int k = 0; k < 4; k++) begin
        rdy_woke[i][k] = rdy_q[i][k] | wb_set[src_tag(op_q[i], k)];
      end
    end
    for (int k = 0; k < 4; k++) begin
      in_rdy[k] = sb_q[src_tag(in_op, k)] | wb_set[src_tag(in_op, k)];
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      op_d[i]    = op_q[i];
      valid_d[i] = valid_q[i];
      rdy_d[i]   = rdy_woke[i];
    end

    // Collapse above the issued slot so index order stays age order.
    if (issue) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          op_d[i]    = op_q[i+1];
          valid_d[i] = valid_q[i+1];
          rdy_d[i]   = rdy_woke[i+1];
        end
      end
      valid_d[DEPTH-1] = 1'b0;
      rdy_d[DEPTH-1]   = '0;
    end

    if (accept) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i == int'(tail)) begin
          op_d[i]    = in_op;
          valid_d[i] = 1'b1;
          rdy_d[i]   = in_rdy;
        end
      end
    end

    count_d = count_q + CNT_W'(accept) - CNT_W'(issue);

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end

    // Clear on accept overrides a same-cycle writeback of the same tag.
    sb_d = sb_q | wb_set;
    if (accept && !flush) begin
      if (dest_val != '0)  sb_d[dest_val]  = 1'b0;
      if (dest_flag != '0) sb_d[dest_flag] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        op_q[i]  <= '0;
        rdy_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
      sb_q    <= '1;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        op_q[i]  <= op_d[i];
        rdy_q[i] <= rdy_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed, table-driven bench for issue_queue: vectors of {inputs, expected outputs}
// plus a hand-written asynchronous reset sequence.
module tb_issue_queue;
  localparam int OPW = 38;

  typedef struct {
    logic           iv;
    logic [OPW-1:0] op;
    logic           ordy;
    logic [4:0]     wbv;
    logic [24:0]    wbt;
    logic           fl;
    logic           eov;
    logic [OPW-1:0] eop;
    logic [3:0]     ecnt;
    logic           eir;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [OPW-1:0] in_op;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] out_op;
  logic           out_valid;
  logic           out_ready;
  logic [24:0]    wb_tags;
  logic [4:0]     wb_valid;
  logic           flush;
  logic [3:0]     count;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  issue_queue #(
    .DEPTH(8), .OP_W(OPW), .PR_ADDR_W(5), .NUM_WB(5)
  ) dut (
    .clk(clk), .rst(rst), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
    .out_op(out_op), .out_valid(out_valid), .out_ready(out_ready), .wb_tags(wb_tags),
    .wb_valid(wb_valid), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [OPW-1:0] mk(input int id, input int s0, input int s1,
                                        input int s2, input int s3, input int dv,
                                        input int df);
    return {df[4:0], dv[4:0], s3[4:0], s2[4:0], s1[4:0], s0[4:0], id[7:0]};
  endfunction

  function automatic logic [24:0] wb1(input int port, input int tag);
    logic [24:0] r;
    r = '0;
    r[port*5 +: 5] = tag[4:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [OPW-1:0] op, input logic ordy,
                     input logic [4:0] wbv, input logic [24:0] wbt, input logic fl,
                     input logic eov, input logic [OPW-1:0] eop, input logic [3:0] ecnt,
                     input logic eir);
    vec_t v;
    v.iv = iv; v.op = op; v.ordy = ordy; v.wbv = wbv; v.wbt = wbt; v.fl = fl;
    v.eov = eov; v.eop = eop; v.ecnt = ecnt; v.eir = eir;
    vecs.push_back(v);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic iv, input logic [OPW-1:0] op, input logic ordy,
                      input logic [4:0] wbv, input logic [24:0] wbt, input logic fl);
    @(negedge clk);
    in_valid = iv; in_op = op; out_ready = ordy; wb_valid = wbv; wb_tags = wbt; flush = fl;
    @(posedge clk);
    #1;
  endtask

  logic [OPW-1:0] op_a, op_a2, op_b, op_c, op_d, op_p, op_x, op_y, op_z, op_f, op_g;
  logic [OPW-1:0] e [8];
  logic [OPW-1:0] r0, r1, r2, r3, r4;

  initial begin
    op_a  = mk(1, 0, 0, 0, 0, 0, 0);
    op_a2 = mk(2, 0, 0, 0, 0, 7, 0);
    op_b  = mk(3, 7, 0, 0, 0, 0, 0);
    op_c  = mk(4, 0, 0, 0, 0, 0, 9);
    op_d  = mk(5, 0, 9, 0, 0, 0, 0);
    op_p  = mk(6, 0, 0, 0, 0, 20, 21);
    op_x  = mk(39, 0, 0, 0, 0, 0, 0);
    op_y  = mk(40, 0, 0, 0, 0, 25, 0);
    op_z  = mk(41, 25, 0, 0, 0, 0, 0);
    op_f  = mk(42, 0, 0, 0, 0, 0, 0);
    op_g  = mk(43, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) e[i] = mk(16 + i, (i == 2 || i == 5) ? 21 : 20, 0, 0, 0, 0, 0);

    // Single ready op, then issue.
    add(1, op_a, 0, 0, 0, 0,  1, op_a, 1, 1);
    add(0, 0,    1, 0, 0, 0,  0, 0,    0, 1);
    // Dependency on tag 7 resolved by writeback port 3.
    add(1, op_a2, 0, 0, 0, 0, 1, op_a2, 1, 1);
    add(1, op_b,  0, 0, 0, 0, 1, op_a2, 2, 1);
    add(0, 0,     1, 0, 0, 0, 0, 0,     1, 1);
    add(0, 0,     0, 0, 0, 0, 0, 0,     1, 1);
    add(0, 0,     0, 5'b01000, wb1(3, 7), 0, 1, op_b, 1, 1);
    add(0, 0,     1, 0, 0, 0, 0, 0,     0, 1);
    // Same-cycle bypass on busy tag 9.
    add(1, op_c, 0, 0, 0, 0, 1, op_c, 1, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    0, 1);
    add(1, op_d, 0, 5'b00001, wb1(0, 9), 0, 1, op_d, 1, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    0, 1);
    // Make tags 20/21 busy, then fill all entries.
    add(1, op_p, 0, 0, 0, 0, 1, op_p, 1, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    0, 1);
    for (int i = 0; i < 8; i++) add(1, e[i], 0, 0, 0, 0, 0, 0, 4'(i + 1), (i < 7));
    // Full: offered op dropped; entries 2 and 5 wake together, 2 goes first.
    add(1, op_x, 1, 5'b00010, wb1(1, 21), 0, 1, e[2], 8, 0);
    add(1, op_x, 1, 0, 0, 0, 1, e[5], 7, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    6, 1);
    // Wake the rest, stall three cycles.
    add(0, 0, 0, 5'b10000, wb1(4, 20), 0, 1, e[0], 6, 1);
    add(0, 0, 0, 0, 0, 0, 1, e[0], 6, 1);
    add(0, 0, 0, 0, 0, 0, 1, e[0], 6, 1);
    add(0, 0, 0, 0, 0, 0, 1, e[0], 6, 1);
    // Flush discards incoming op and leaves the scoreboard untouched.
    add(1, op_y, 1, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0,    0, 0, 0, 0, 0, 0, 0, 1);
    add(1, op_z, 0, 0, 0, 0, 1, op_z, 1, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    0, 1);
    // Simultaneous issue and accept.
    add(1, op_f, 1, 0, 0, 0, 1, op_f, 1, 1);
    add(1, op_g, 1, 0, 0, 0, 1, op_g, 1, 1);
    add(0, 0,    1, 0, 0, 0, 0, 0,    0, 1);

    rst = 1'b1;
    in_valid = 0; in_op = '0; out_ready = 0; wb_valid = '0; wb_tags = '0; flush = 0;
    #12;
    chk("reset count", count, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_op", out_op, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].op, vecs[i].ordy, vecs[i].wbv, vecs[i].wbt, vecs[i].fl);
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].eov);
      chk($sformatf("v%0d count", i), count, vecs[i].ecnt);
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].eir);
      if (vecs[i].eov) chk($sformatf("v%0d out_op", i), out_op, vecs[i].eop);
    end

    // Asynchronous reset with four resident entries.
    r0 = mk(50, 0, 0, 0, 0, 30, 0);
    r1 = mk(51, 30, 0, 0, 0, 0, 0);
    r2 = mk(52, 30, 0, 0, 0, 0, 0);
    r3 = mk(53, 30, 0, 0, 0, 0, 0);
    r4 = mk(54, 30, 0, 0, 0, 0, 0);
    step(1, r0, 0, 0, 0, 0);
    step(1, r1, 0, 0, 0, 0);
    step(1, r2, 0, 0, 0, 0);
    step(1, r3, 0, 0, 0, 0);
    chk("pre-reset count", count, 4);
    chk("pre-reset out_valid", out_valid, 1);
    chk("pre-reset out_op", out_op, r0);
    @(negedge clk);
    in_valid = 0; in_op = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async reset count", count, 0);
    chk("async reset out_valid", out_valid, 0);
    chk("async reset in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step(1, r4, 0, 0, 0, 0);
    chk("post-reset scoreboard out_valid", out_valid, 1);
    chk("post-reset out_op", out_op, r4);
    chk("post-reset count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Age-ordered out-of-order issue queue between the renamer/dispatch stage and one middle-end pipeline port (arith, mem or term). It buffers renamed ops, tracks physical-register readiness from the middle-end writeback buses, and presents the oldest op whose source operands are all ready. The block keeps a full physical-register scoreboard, so each pipeline port gets its own instance.

## Interface
Parameters:
- DEPTH, 8, number of queue entries (≥2)
- OP_W, `RENAMED_OP_SZ, renamed-op width
- PR_ADDR_W, `PR_ADDR_W, physical-register tag width
- NUM_WB, 5, writeback ports observed

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_op  in  OP_W  renamed op from dispatch
- in_valid  in  1  in_op present
- in_ready  out  1  queue can accept; equals !full
- out_op  out  OP_W  selected op, to the pipeline instr input
- out_valid  out  1  out_op is issuable
- out_ready  in  1  pipeline accepts; tie high for arith/mem ports
- wb_tags  in  PR_ADDR_W*NUM_WB  writeback tags (middle-end phys_dest_regs_out)
- wb_valid  in  NUM_WB  per-port writeback enable (middle-end reg_writes)
- flush  in  1  synchronous squash of all entries (term failure)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Op fields: sources are four PR tags at in_op[8 + 5k +: PR_ADDR_W], k=0..3. Destinations are [28 +: 5] (value) and [33 +: 5] (flags).
- Tag 0 is always ready. It is never marked busy.
- Scoreboard: 2^PR_ADDR_W ready bits. All bits are 1 after reset.
  - On accept, each nonzero destination tag of in_op is cleared.
  - On wb_valid[i], wb_tags[i] is set.
  - If the same tag is cleared by accept and set by writeback in one cycle, the clear wins.
- Entry state: op, valid, rdy[3:0].
- Accept (in_valid && in_ready): the op is written at the tail, position count.
  - rdy[k] = scoreboard[src_k] OR any same-cycle wb_tags match on src_k (bypass).
- Wakeup: each valid entry sets rdy[k] when any wb_valid port's tag equals its src_k. rdy bits never clear while the entry is resident.
- Select: oldest (lowest index) valid entry with all four rdy bits set.
  - out_valid = such an entry exists.
  - out_op = that entry's op.
  - Both are combinational from registered state only, with no path from in_* or wb_*.
- Issue (out_valid && out_ready): the selected entry is removed. Younger entries shift down one slot, which preserves age order.
- Simultaneous issue and accept: the new op lands at count-1 after the collapse. The net count is unchanged.
- A full queue deasserts in_ready even if an issue happens that cycle (no ready loop).
- flush: all valid bits clear next edge, and count becomes 0. An accept or issue in the same cycle is discarded. The flush does not alter the scoreboard; writebacks in that cycle still set bits.
- out_op holds entry 0's contents when out_valid=0. Consumers must ignore it.

## Timing
- Reset values, asserted asynchronously:
  - count=0, all entries invalid, scoreboard all 1
  - out_valid=0, in_ready=1, out_op=0
- Minimum latency: an op accepted at edge N with ready sources gives out_valid during cycle N+1.
- Wakeup latency: a writeback visible at edge N makes the dependent entry selectable in cycle N+1.
- Back-to-back: one accept and one issue per cycle, sustained.
- Stall: out_op/out_valid stay stable while out_valid && !out_ready, unless an older entry becomes ready. In that case the selection switches to the older op. The term pipeline tolerates this because it registers on accept.
- Reset mid-operation drops all entries immediately, with no partial issue.

## Test plan
- Reset then a single op with sources 0,0,0,0: accept at edge 1 -> out_valid=1 in cycle 2 with out_op equal to the input. Issue -> count returns 0.
- Dependency: op A has dest 7; op B has src 7, accepted next. B is not issued until wb_valid[3] with tag 7 arrives at edge N. B's out_valid must rise in cycle N+1, not N.
- Bypass: accept an op with src 9 in the same cycle as wb tag 9 (9 previously busy) -> out_valid the next cycle.
- Age order: fill all 8 entries; make entries 5 and 2 ready together -> entry 2 issues first, then 5. Check in_ready=0 while full and count=8.
- Stall plus flush: out_ready=0 holds out_op for 3 cycles. flush asserted with in_valid=1 -> next cycle count=0, out_valid=0, and the incoming op is discarded.
- Async reset asserted mid-cycle with 4 entries -> out_valid and count drop before the next edge. The scoreboard reads all-ready after release.
